// File: rtl/timer_irq.sv
// timer_irq: memory-mapped interval timer raising a level IRQ on TL overflow, plus a free-running SYSTICK.
// Define TIMER_PRESCALE_EN to add the PS prescaler register and its tick down-counter.
module timer_irq #(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter logic [31:0] TH_RESET  = 32'hFFFF_F000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        mem_write,
    input  logic        mem_read,
    output logic [31:0] rdata,
    output logic        hit,
    output logic        irq
);
    logic [31:0] th_q, th_d, tl_q, tl_d, sys_q, sys_d, ps_val;
    logic        en_q, en_d, ie_q, ie_d, st_q, st_d;
    logic [2:0]  off;
    logic        wr, tick, ovf;
    assign hit = (addr & ~32'h1F) == BASE_ADDR;
    assign off = addr[4:2];
    assign wr  = hit && mem_write;
    assign ovf = en_q && tick && (tl_q == '1);
    assign irq = ie_q && st_q;
`ifdef TIMER_PRESCALE_EN
    logic [31:0] ps_q, ps_d, pc_q, pc_d;
    assign tick   = pc_q == '0;
    assign ps_val = ps_q;
    // a PS write also restarts the down-counter so the new rate applies at once
    always_comb begin
        ps_d = (wr && off == 3'd3) ? wdata : ps_q;
        pc_d = (wr && off == 3'd3) ? wdata : !en_q ? pc_q : tick ? ps_q : pc_q - 32'd1;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ps_q <= '0;
            pc_q <= '0;
        end else begin
            ps_q <= ps_d;
            pc_q <= pc_d;
        end
    end
`else
    assign tick   = 1'b1;
    assign ps_val = '0;
`endif
    // a software write to TL beats the reload; the hardware ST set beats a TCON write
    always_comb begin
        th_d  = (wr && off == 3'd0) ? wdata : th_q;
        tl_d  = (wr && off == 3'd1) ? wdata : ovf ? th_q : (en_q && tick) ? tl_q + 32'd1 : tl_q;
        en_d  = (wr && off == 3'd2) ? wdata[0] : en_q;
        ie_d  = (wr && off == 3'd2) ? wdata[1] : ie_q;
        st_d  = ((wr && off == 3'd2) ? wdata[2] : st_q) | (ovf && (ie_q || (wr && off == 3'd2 && wdata[1])));
        sys_d = (wr && off == 3'd5) ? wdata : sys_q + 32'd1;
    end
    always_comb begin
        rdata = !(hit && mem_read) ? '0 :
                off == 3'd0 ? th_q :
                off == 3'd1 ? tl_q :
                off == 3'd2 ? {29'd0, st_q, ie_q, en_q} :
                off == 3'd3 ? ps_val :
                off == 3'd5 ? sys_q : '0;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            th_q  <= TH_RESET;
            tl_q  <= '0;
            en_q  <= 1'b0;
            ie_q  <= 1'b0;
            st_q  <= 1'b0;
            sys_q <= '0;
        end else begin
            th_q  <= th_d;
            tl_q  <= tl_d;
            en_q  <= en_d;
            ie_q  <= ie_d;
            st_q  <= st_d;
            sys_q <= sys_d;
        end
    end
endmodule

// File: tb/tb_timer_irq.sv
// tb_timer_irq: vector table, corner-case sequences and randomized traffic against a reference model.
module tb_timer_irq;
    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam logic [31:0] THR  = 32'hFFFF_F000;
    logic        clk = 1'b0, reset_n = 1'b0;
    logic [31:0] addr = '0, wdata = '0, rdata;
    logic        mem_write = 1'b0, mem_read = 1'b0, hit, irq;
    int          n_chk = 0, n_fail = 0;

    timer_irq #(.BASE_ADDR(BASE), .TH_RESET(THR)) dut (
        .clk(clk), .reset_n(reset_n), .addr(addr), .wdata(wdata),
        .mem_write(mem_write), .mem_read(mem_read),
        .rdata(rdata), .hit(hit), .irq(irq)
    );

    initial forever #5 clk = ~clk;

    // reference model: register file as plain variables, one update per rising edge
    logic [31:0] m_th, m_tl, m_sys, m_ps, m_pc;
    logic        m_en, m_ie, m_st, m_w, m_tk, m_ov, m_set;
    int          m_o;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_th = THR; m_tl = 0; m_en = 0; m_ie = 0; m_st = 0; m_sys = 0; m_ps = 0; m_pc = 0;
        end else begin
            m_o = int'(addr[4:2]);
            m_w = mem_write && ((addr & ~32'h1F) == BASE);
            m_tk = 1'b1;
`ifdef TIMER_PRESCALE_EN
            m_tk = (m_pc == 0);
            if (m_en) m_pc = m_tk ? m_ps : m_pc - 1;
            if (m_w && m_o == 3) begin m_ps = wdata; m_pc = wdata; end
`endif
            m_ov = m_en && m_tk && (m_tl == 32'hFFFF_FFFF);
            m_set = m_ov && (m_ie || (m_w && m_o == 2 && wdata[1]));
            if (m_en && m_tk) m_tl = m_ov ? m_th : m_tl + 1;
            m_sys = m_sys + 1;
            if (m_w) begin
                if (m_o == 0) m_th = wdata;
                if (m_o == 1) m_tl = wdata;
                if (m_o == 2) begin m_en = wdata[0]; m_ie = wdata[1]; m_st = wdata[2]; end
                if (m_o == 5) m_sys = wdata;
            end
            if (m_set) m_st = 1'b1;
        end
    end

    function automatic logic [31:0] m_read(input logic [31:0] a, input logic re);
        if (!(re && (a & ~32'h1F) == BASE)) return 0;
        case (a[4:2])
            3'd0: return m_th;
            3'd1: return m_tl;
            3'd2: return {29'd0, m_st, m_ie, m_en};
`ifdef TIMER_PRESCALE_EN
            3'd3: return m_ps;
`endif
            3'd5: return m_sys;
            default: return 0;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic apply(input logic [31:0] a, input logic [31:0] d, input logic we, input logic re);
        @(negedge clk);
        addr = a; wdata = d; mem_write = we; mem_read = re;
        #1;
    endtask

    typedef struct {
        logic [31:0] a, wd;
        logic        we, re;
        logic [31:0] rd;
        logic        hit, irq;
    } vec_t;
    vec_t tv[$];
    function automatic void v(logic [31:0] a, logic [31:0] wd, logic we, logic re,
                              logic [31:0] rd, logic h, logic i);
        vec_t t;
        t.a = a; t.wd = wd; t.we = we; t.re = re; t.rd = rd; t.hit = h; t.irq = i;
        tv.push_back(t);
    endfunction

    initial begin
        logic [31:0] a, d;
        // vectors run from reset; each row is one cycle, outputs checked before its edge
        v(BASE+32'h00, 0, 0, 1, THR, 1, 0);
        v(BASE+32'h04, 0, 0, 1, 32'h0, 1, 0);
        v(BASE+32'h08, 0, 0, 1, 32'h0, 1, 0);
        v(BASE+32'h0C, 0, 0, 1, 32'h0, 1, 0);
        v(BASE+32'h10, 0, 0, 1, 32'h0, 1, 0);
        v(BASE+32'h18, 0, 0, 1, 32'h0, 1, 0);
        v(BASE+32'h20, 0, 0, 1, 32'h0, 0, 0);
        v(32'h3FFF_FFFC, 0, 0, 1, 32'h0, 0, 0);
        v(BASE+32'h00, 32'hFFFF_FFFC, 1, 0, 32'h0, 1, 0);
        v(BASE+32'h04, 32'hFFFF_FFFC, 1, 0, 32'h0, 1, 0);
        v(BASE+32'h08, 32'h3, 1, 0, 32'h0, 1, 0);
        v(BASE+32'h05, 0, 0, 1, 32'hFFFF_FFFC, 1, 0);
        v(BASE+32'h04, 0, 0, 1, 32'hFFFF_FFFD, 1, 0);
        v(BASE+32'h04, 0, 0, 1, 32'hFFFF_FFFE, 1, 0);
        v(BASE+32'h08, 0, 0, 1, 32'h3, 1, 0);
        v(BASE+32'h08, 0, 0, 1, 32'h7, 1, 1);
        v(BASE+32'h04, 0, 0, 1, 32'hFFFF_FFFD, 1, 1);
        v(BASE+32'h08, 32'h3, 1, 0, 32'h0, 1, 1);
        v(BASE+32'h08, 32'h3, 1, 0, 32'h0, 1, 0);
        v(BASE+32'h08, 0, 0, 1, 32'h7, 1, 1);
        v(BASE+32'h04, 0, 0, 1, 32'hFFFF_FFFD, 1, 1);
        v(BASE+32'h04, 0, 0, 1, 32'hFFFF_FFFE, 1, 1);
        v(BASE+32'h04, 32'h10, 1, 0, 32'h0, 1, 1);
        v(BASE+32'h04, 0, 0, 1, 32'h10, 1, 1);
        v(BASE+32'h04, 0, 0, 1, 32'h11, 1, 1);
        v(BASE+32'h08, 32'h1, 1, 0, 32'h0, 1, 1);
        v(BASE+32'h08, 0, 0, 1, 32'h1, 1, 0);
        v(BASE+32'h04, 32'hFFFF_FFFE, 1, 0, 32'h0, 1, 0);
        v(BASE+32'h04, 0, 0, 1, 32'hFFFF_FFFE, 1, 0);
        v(BASE+32'h04, 0, 0, 1, 32'hFFFF_FFFF, 1, 0);
        v(BASE+32'h04, 0, 0, 1, 32'hFFFF_FFFC, 1, 0);
        v(BASE+32'h08, 0, 0, 1, 32'h1, 1, 0);
        v(BASE+32'h14, 32'h100, 1, 0, 32'h0, 1, 0);
        v(BASE+32'h14, 0, 0, 1, 32'h100, 1, 0);
        v(BASE+32'h14, 0, 0, 1, 32'h101, 1, 0);
        v(BASE+32'h14, 32'hFFFF_FFFF, 1, 0, 32'h0, 1, 0);
        v(BASE+32'h14, 0, 0, 1, 32'hFFFF_FFFF, 1, 0);
        v(BASE+32'h14, 0, 0, 1, 32'h0, 1, 0);
        v(BASE+32'h10, 32'hDEAD_BEEF, 1, 0, 32'h0, 1, 0);
        v(BASE+32'h10, 0, 0, 1, 32'h0, 1, 0);
        v(BASE+32'h08, 32'hFFFF_FFF8, 1, 0, 32'h0, 1, 0);
        v(BASE+32'h08, 0, 0, 1, 32'h0, 1, 0);
        v(BASE+32'h04, 0, 0, 1, 32'hFFFF_FFFF, 1, 0);
        v(BASE+32'h04, 0, 0, 1, 32'hFFFF_FFFF, 1, 0);
        v(BASE+32'h00, 0, 0, 0, 32'h0, 1, 0);

        repeat (3) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;

        // asynchronous reset mid-count with irq pending
        apply(BASE+32'h00, 32'hFFFF_FFFC, 1, 0);
        apply(BASE+32'h04, 32'hFFFF_FFFF, 1, 0);
        apply(BASE+32'h08, 32'h3, 1, 0);
        apply(0, 0, 0, 0);
        chk("pre_ovf_irq", {31'd0, irq}, 32'd0);
        apply(0, 0, 0, 0);
        chk("ovf_irq", {31'd0, irq}, 32'd1);
        #2 reset_n = 1'b0;
        #1 chk("rst_irq", {31'd0, irq}, 32'd0);
        addr = BASE; mem_read = 1'b1;
        #1 chk("rst_th", rdata, THR);
        addr = BASE + 32'h4;
        #1 chk("rst_tl", rdata, 32'h0);
        addr = BASE + 32'h8;
        #1 chk("rst_tcon", rdata, 32'h0);
        @(negedge clk) reset_n = 1'b1;

        foreach (tv[i]) begin
            apply(tv[i].a, tv[i].wd, tv[i].we, tv[i].re);
            chk($sformatf("vec%0d_rdata", i), rdata, tv[i].rd);
            chk($sformatf("vec%0d_hit", i), {31'd0, hit}, {31'd0, tv[i].hit});
            chk($sformatf("vec%0d_irq", i), {31'd0, irq}, {31'd0, tv[i].irq});
        end

        // prescaler: PS=3 gives one TL increment every 4 enabled cycles
        apply(BASE+32'h0C, 32'h3, 1, 0);
        apply(BASE+32'h0C, 0, 0, 1);
`ifdef TIMER_PRESCALE_EN
        chk("ps_read", rdata, 32'h3);
`else
        chk("ps_read", rdata, 32'h0);
`endif
        apply(BASE+32'h04, 32'h0, 1, 0);
        apply(BASE+32'h08, 32'h1, 1, 0);
        repeat (8) apply(0, 0, 0, 0);
        apply(BASE+32'h04, 0, 0, 1);
`ifdef TIMER_PRESCALE_EN
        chk("ps_tl_after8", rdata, 32'h2);
`else
        chk("ps_tl_after8", rdata, 32'h8);
`endif

        for (int i = 0; i < 3000; i++) begin
            a = ($urandom_range(0, 9) < 8) ? BASE + ($urandom_range(0, 7) << 2) + $urandom_range(0, 3)
                                           : ($urandom_range(0, 1) ? BASE + 32'h20 : $urandom);
            d = $urandom_range(0, 1) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom;
            if (a[4:2] == 3'd3) d = $urandom_range(0, 3);
            if (a[4:2] == 3'd2 && $urandom_range(0, 1)) d = d | 32'h3;
            apply(a, d, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
            chk($sformatf("rnd%0d_rdata", i), rdata, m_read(a, mem_read));
            chk($sformatf("rnd%0d_hit", i), {31'd0, hit}, {31'd0, (a & ~32'h1F) == BASE});
            chk($sformatf("rnd%0d_irq", i), {31'd0, irq}, {31'd0, m_ie && m_st});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
